// File: rtl/digit_scan_if.sv
// Counter-to-display bus: run controls and packed digits in,
// scanned 7-segment digit stream out.
interface digit_scan_if #(
  parameter int NDIG = 12
);
  logic              en;
  logic              freeze;
  logic              lzb;
  logic [5*NDIG-1:0] digits_in;
  logic [6:0]        seg;
  logic [3:0]        dig_idx;
  logic              dig_valid;
  logic              frame_done;

  modport master (
    output en, freeze, lzb, digits_in,
    input  seg, dig_idx, dig_valid, frame_done
  );

  modport slave (
    input  en, freeze, lzb, digits_in,
    output seg, dig_idx, dig_valid, frame_done
  );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Frame-coherent digit scanner: snapshots all BCD digits, then drives
// them one at a time onto a shared 7-segment bus with blanking gaps.
module digit_scan_ctrl #(
  parameter int NDIG  = 12,
  parameter int DWELL = 4,
  parameter int GAP   = 1
) (
  input  logic         CLK,
  input  logic         RST,
  digit_scan_if.slave  bus
);

  localparam int CMAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int GL   = (GAP > 0) ? GAP - 1 : 0;

  localparam logic [CW-1:0] D_END = CW'(DWELL - 1);
  localparam logic [CW-1:0] G_END = CW'(GL);
  localparam logic [3:0]    LAST  = 4'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE,
    SNAP,
    SHOW,
    GAPS
  } st_t;

  typedef logic [NDIG-1:0][4:0] dvec_t;

  st_t           st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  dvec_t         snap, snap_n;
  logic          lzb_q, lzb_n;
  logic [3:0]    msd, msd_n;
  logic [3:0]    idx_q, idx_n;
  logic [6:0]    seg_q, seg_n;
  logic          vld_q, vld_n;
  logic          fd_q, fd_n;
  logic          adv;
  logic          last_n;

  function automatic logic [6:0] enc(input logic [4:0] d);
    logic [6:0] s;
    case (d)
      5'd0:    s = 7'h3F;
      5'd1:    s = 7'h06;
      5'd2:    s = 7'h5B;
      5'd3:    s = 7'h4F;
      5'd4:    s = 7'h66;
      5'd5:    s = 7'h6D;
      5'd6:    s = 7'h7D;
      5'd7:    s = 7'h07;
      5'd8:    s = 7'h7F;
      5'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Illegal codes count as nonzero so they are never blanked.
  function automatic logic [3:0] msd_of(input dvec_t v);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (v[i] != 5'd0) m = 4'(i);
    end
    return m;
  endfunction

  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    snap_n = snap;
    lzb_n  = lzb_q;
    msd_n  = msd;
    idx_n  = idx_q;
    adv    = 1'b0;

    unique case (st)
      IDLE: begin
        if (bus.en) st_n = SNAP;
      end
      SNAP: begin
        if (!bus.freeze) snap_n = bus.digits_in;
        lzb_n = bus.lzb;
        msd_n = msd_of(snap_n);
        idx_n = '0;
        cnt_n = '0;
        st_n  = SHOW;
      end
      SHOW: begin
        if (cnt == D_END) begin
          cnt_n = '0;
          if (GAP > 0) st_n = GAPS;
          else         adv  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAPS: begin
        if (cnt == G_END) begin
          cnt_n = '0;
          adv   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: st_n = IDLE;
    endcase

    if (adv) begin
      if (idx_q == LAST) begin
        st_n = bus.en ? SNAP : IDLE;
      end else begin
        idx_n = idx_q + 1'b1;
        st_n  = SHOW;
      end
    end

    // Outputs are computed for the state being entered.
    if (GAP > 0) last_n = (st_n == GAPS) && (cnt_n == G_END);
    else         last_n = (st_n == SHOW) && (cnt_n == D_END);

    fd_n  = last_n && (idx_n == LAST);
    vld_n = (st_n == SHOW);
    seg_n = '0;
    if (vld_n && !(lzb_n && (idx_n > msd_n)))
      seg_n = enc(snap_n[idx_n]);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st    <= IDLE;
      cnt   <= '0;
      snap  <= '0;
      lzb_q <= 1'b0;
      msd   <= '0;
      idx_q <= '0;
      seg_q <= '0;
      vld_q <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      st    <= st_n;
      cnt   <= cnt_n;
      snap  <= snap_n;
      lzb_q <= lzb_n;
      msd   <= msd_n;
      idx_q <= idx_n;
      seg_q <= seg_n;
      vld_q <= vld_n;
      fd_q  <= fd_n;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dig_idx    = idx_q;
  assign bus.dig_valid  = vld_q;
  assign bus.frame_done = fd_q;

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
- Display sequencer for the 12-digit BCD counter datapath: ones, tens, ..., hundred-billions; 5-bit digit fields, 60-bit packed bus.
- Takes a coherent snapshot of all digits at the start of each frame.
- Scans the digits one at a time onto a shared 7-segment bus with a digit index, optional leading-zero blanking, and an inter-digit blanking gap.
- Sits between the counter outputs and the pin-limited io_out bus.

Parameters:
- NDIG, 12, number of digits scanned (index 0 = ones).
- DWELL, 4, cycles each digit is driven (>=1).
- GAP, 1, blank cycles after each digit (>=0; 0 = no gap state).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- en  input  1  run enable; sampled every cycle.
- freeze  input  1  when 1 at SNAP, snapshot is not updated (hold display).
- lzb  input  1  leading-zero blanking enable; sampled at SNAP.
- digits_in  input  5*NDIG  packed digits; digit i at [5i+4:5i].
- seg  output  7  {g,f,e,d,c,b,a}, active-high.
- dig_idx  output  4  index of digit currently driven.
- dig_valid  output  1  1 while seg shows a digit (SHOW state).
- frame_done  output  1  one-cycle pulse on the last GAP/SHOW cycle of digit NDIG-1.

Behaviour:
- All outputs registered. On RST: state IDLE, seg=0, dig_idx=0, dig_valid=0, frame_done=0, snapshot=0, dwell/gap counters=0. Reset mid-frame aborts immediately; no partial frame_done.
- States: IDLE, SNAP, SHOW, GAP.
- IDLE:
  - seg=0, dig_valid=0.
  - en=1 -> SNAP next cycle.
- SNAP (exactly 1 cycle):
  - If freeze=0: snapshot <= digits_in.
  - Latch lzb.
  - msd <= highest index with nonzero snapshot digit; msd=0 if all digits are zero. msd is computed from the value being stored.
  - dig_idx <= 0. Next state SHOW.
- SHOW (DWELL cycles):
  - dig_valid=1.
  - seg = blank (0) if lzb_latched and dig_idx>msd; otherwise encode(snapshot[dig_idx]).
  - After DWELL cycles: GAP if GAP>0, else behave as GAP exit.
- GAP (GAP cycles):
  - seg=0, dig_valid=0, dig_idx held.
  - On exit, if dig_idx<NDIG-1: dig_idx+1 and go to SHOW.
  - On exit, if dig_idx=NDIG-1: frame_done=1 on this final cycle, then SNAP if en=1, else IDLE.
- en deassert mid-frame: the current frame completes, including frame_done; then IDLE. en is ignored except in IDLE and at frame end.
- Encoding (hex of seg): 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F. Values 10..31 are illegal BCD and display 40 (dash); they count as nonzero for msd.
- Latency: en=1 sampled at edge k -> SNAP during cycle k+1 -> first SHOW at k+2.
- Frame period: 1 + NDIG*(DWELL+GAP) cycles, which is 61 at the defaults. Back-to-back frames have no idle cycle.
- digits_in changing during SHOW/GAP has no effect until the next SNAP.

Test Plan:
- Reset then en=1, digits_in=ones..hunB = 1,2,...,9,0,1,2, lzb=0 -> seg sequence 06,5B,4F,66,6D,7D,07,7F,6F,3F,06,5B. Each value held 4 cycles with a 1-cycle 00 gap; frame_done at cycle 61 after SNAP.
- lzb=1, digits_in = 0 except tens=4 -> idx0 shows 3F, idx1 shows 66, idx2..11 show 00 while dig_valid=1. With all digits zero, only idx0 shows 3F.
- freeze=1 at the second SNAP after digits_in changed from 5s to 7s -> second frame still shows 6D on every digit. freeze=0 on the third frame shows 07.
- Illegal digit: hundreds=5'd13 -> idx2 shows 40. With lzb=1 and all higher digits zero, idx2 is not blanked.
- en dropped mid-frame at idx5 -> frame finishes to idx11, frame_done pulses once, then IDLE with seg=00. RST asserted during SHOW idx3 -> outputs 0 immediately, with no frame_done.
- Parameter sweep DWELL=1, GAP=0 -> a new digit every cycle, frame period 13, dig_valid held high throughout.
